// File: rtl/game_pkg.sv
// Shared game-flow types and defaults used by the score block and the level flow controller.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } game_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int GEM_TOTAL_DEF      = 2;
  localparam int FRAMES_PER_SEC_DEF = 60;

  // Converts a seconds value into three packed BCD digits {hundreds, tens, ones}.
  function automatic logic [11:0] bin_to_bcd(input logic [7:0] value);
    int unsigned v;
    v = int'(value);
    return {bcd_digit_t'(v / 100), bcd_digit_t'((v / 10) % 10), bcd_digit_t'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD up-counter with synchronous clear, enable and a hold-at-value limit.
module bcd_counter3
  import game_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [11:0] sat_i,
  output logic [11:0] value_o
);

  bcd_digit_t [2:0] digits_q, digits_d;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    digits_d = digits_q;
    if (clr_i) begin
      digits_d = '0;
    end else if (en_i && (digits_q != sat_i)) begin
      if (digits_q[0] == 4'd9) begin
        digits_d[0] = 4'd0;
        if (digits_q[1] == 4'd9) begin
          digits_d[1] = 4'd0;
          digits_d[2] = (digits_q[2] == 4'd9) ? 4'd0 : digits_q[2] + 4'd1;
        end else begin
          digits_d[1] = digits_q[1] + 4'd1;
        end
      end else begin
        digits_d[0] = digits_q[0] + 4'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) digits_q <= '0;
    else       digits_q <= digits_d;
  end

  assign value_o = digits_q;

endmodule

// File: rtl/level_flow_controller.sv
// Level flow FSM: idle/play/win/lose sequencing, level timer (binary + BCD), best time and
// the freeze / level_reset controls returned to the player, gem and score logic.
module level_flow_controller
  import game_pkg::*;
#(
  parameter int GEM_TOTAL      = GEM_TOTAL_DEF,
  parameter int FRAMES_PER_SEC = FRAMES_PER_SEC_DEF,
  parameter int TIME_LIMIT_S   = 255,
  parameter int HOLD_FRAMES    = 120
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        start_key,
  input  logic [3:0]  score,
  input  logic        p1_at_door,
  input  logic        p2_at_door,
  input  logic        p1_hazard,
  input  logic        p2_hazard,
  output logic [1:0]  state,
  output logic        freeze,
  output logic        level_reset,
  output logic [7:0]  elapsed_s,
  output logic [11:0] elapsed_bcd,
  output logic [7:0]  best_s,
  output logic        best_valid
);

  localparam int FW = $clog2(FRAMES_PER_SEC);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_FRAMES);
  localparam logic [7:0]    LIMIT      = 8'(TIME_LIMIT_S);
  localparam logic [11:0]   LIMIT_BCD  = bin_to_bcd(LIMIT);

  game_state_e   state_q;
  logic          freeze_q, level_reset_q, best_valid_q;
  logic [FW-1:0] frame_cnt_q;
  logic [HW-1:0] hold_cnt_q;
  logic [7:0]    elapsed_q, best_q;

  logic restart, lose_now, win_now, frame_tick, sec_tick, in_end;

  always_comb begin
    in_end     = (state_q == ST_WIN) || (state_q == ST_LOSE);
    restart    = start_key && ((state_q == ST_IDLE) || (in_end && (hold_cnt_q == HOLD_MAX)));
    lose_now   = (state_q == ST_PLAY) && (p1_hazard || p2_hazard || (elapsed_q == LIMIT));
    win_now    = (state_q == ST_PLAY) && !lose_now && p1_at_door && p2_at_door &&
                 (score >= 4'(GEM_TOTAL));
    // The timer only advances on cycles where PLAY is not being left.
    frame_tick = (state_q == ST_PLAY) && !lose_now && !win_now && frame_start;
    sec_tick   = frame_tick && (frame_cnt_q == FRAME_LAST) && (elapsed_q != LIMIT);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      freeze_q      <= 1'b1;
      level_reset_q <= 1'b0;
      elapsed_q     <= '0;
      frame_cnt_q   <= '0;
      hold_cnt_q    <= '0;
      best_q        <= '0;
      best_valid_q  <= 1'b0;
    end else begin
      level_reset_q <= restart;
      if (restart) begin
        state_q     <= ST_PLAY;
        freeze_q    <= 1'b0;
        elapsed_q   <= '0;
        frame_cnt_q <= '0;
      end else if (lose_now) begin
        state_q    <= ST_LOSE;
        freeze_q   <= 1'b1;
        hold_cnt_q <= '0;
      end else if (win_now) begin
        state_q    <= ST_WIN;
        freeze_q   <= 1'b1;
        hold_cnt_q <= '0;
        if (!best_valid_q || (elapsed_q < best_q)) begin
          best_q       <= elapsed_q;
          best_valid_q <= 1'b1;
        end
      end else begin
        if (frame_tick) begin
          frame_cnt_q <= (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + 1'b1;
          if (sec_tick) elapsed_q <= elapsed_q + 8'd1;
        end
        if (in_end && frame_start && (hold_cnt_q != HOLD_MAX)) hold_cnt_q <= hold_cnt_q + 1'b1;
      end
    end
  end

  bcd_counter3 u_bcd (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr_i   (restart),
    .en_i    (sec_tick),
    .sat_i   (LIMIT_BCD),
    .value_o (elapsed_bcd)
  );

  assign state       = state_q;
  assign freeze      = freeze_q;
  assign level_reset = level_reset_q;
  assign elapsed_s   = elapsed_q;
  assign best_s      = best_q;
  assign best_valid  = best_valid_q;

endmodule

// File: tb/tb_level_flow_controller.sv
// Directed bench: one controller with a long time limit, a second with a 3 s limit, shared stimulus.
module tb_level_flow_controller;

  logic       Clk = 1'b0;
  logic       Reset, frame_start, start_key;
  logic [3:0] score;
  logic       p1_at_door, p2_at_door, p1_hazard, p2_hazard;

  logic [1:0]  a_state, b_state;
  logic        a_freeze, b_freeze, a_lr, b_lr, a_bv, b_bv;
  logic [7:0]  a_el, b_el, a_best, b_best;
  logic [11:0] a_bcd, b_bcd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  level_flow_controller #(.GEM_TOTAL(2), .FRAMES_PER_SEC(4), .TIME_LIMIT_S(200), .HOLD_FRAMES(3)) u_a (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .start_key(start_key), .score(score),
    .p1_at_door(p1_at_door), .p2_at_door(p2_at_door), .p1_hazard(p1_hazard), .p2_hazard(p2_hazard),
    .state(a_state), .freeze(a_freeze), .level_reset(a_lr), .elapsed_s(a_el),
    .elapsed_bcd(a_bcd), .best_s(a_best), .best_valid(a_bv)
  );

  level_flow_controller #(.GEM_TOTAL(2), .FRAMES_PER_SEC(4), .TIME_LIMIT_S(3), .HOLD_FRAMES(3)) u_b (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .start_key(start_key), .score(score),
    .p1_at_door(p1_at_door), .p2_at_door(p2_at_door), .p1_hazard(p1_hazard), .p2_hazard(p2_hazard),
    .state(b_state), .freeze(b_freeze), .level_reset(b_lr), .elapsed_s(b_el),
    .elapsed_bcd(b_bcd), .best_s(b_best), .best_valid(b_bv)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1; step();
      frame_start = 1'b0; step();
    end
  endtask

  task automatic restart_a();
    start_key = 1'b1; step();
    start_key = 1'b0;
    check("restart_state", 32'(a_state), 32'h1);
    check("restart_lr", 32'(a_lr), 32'h1);
    check("restart_elapsed", 32'(a_el), 32'h0);
    step();
    check("restart_lr_drop", 32'(a_lr), 32'h0);
  endtask

  task automatic win_a();
    score = 4'd2; p1_at_door = 1'b1; p2_at_door = 1'b1; step();
    p1_at_door = 1'b0; p2_at_door = 1'b0;
    check("win_state", 32'(a_state), 32'h2);
    check("win_freeze", 32'(a_freeze), 32'h1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(a_state), 32'h0);
    check({tag, "_freeze"}, 32'(a_freeze), 32'h1);
    check({tag, "_lr"}, 32'(a_lr), 32'h0);
    check({tag, "_elapsed"}, 32'(a_el), 32'h0);
    check({tag, "_bcd"}, 32'(a_bcd), 32'h0);
    check({tag, "_best"}, 32'(a_best), 32'h0);
    check({tag, "_bvalid"}, 32'(a_bv), 32'h0);
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; start_key = 1'b0; score = 4'd0;
    p1_at_door = 1'b0; p2_at_door = 1'b0; p1_hazard = 1'b0; p2_hazard = 1'b0;
    step(); step();
    check_reset_values("rst");
    Reset = 1'b0; step();

    // Start with a simultaneous frame pulse: frame must not be counted.
    start_key = 1'b1; frame_start = 1'b1; step();
    start_key = 1'b0; frame_start = 1'b0;
    check("start_state", 32'(a_state), 32'h1);
    check("start_lr", 32'(a_lr), 32'h1);
    check("start_freeze", 32'(a_freeze), 32'h0);
    check("start_elapsed", 32'(a_el), 32'h0);
    step();
    check("start_lr_drop", 32'(a_lr), 32'h0);

    frames(36);
    check("t9_elapsed", 32'(a_el), 32'd9);
    check("t9_bcd", 32'(a_bcd), 32'h009);
    frames(4);
    check("t10_elapsed", 32'(a_el), 32'd10);
    check("t10_bcd", 32'(a_bcd), 32'h010);

    // Hazard has priority over a simultaneous win condition.
    score = 4'd2; p1_at_door = 1'b1; p2_at_door = 1'b1; p1_hazard = 1'b1; step();
    p1_at_door = 1'b0; p2_at_door = 1'b0; p1_hazard = 1'b0;
    check("haz_state", 32'(a_state), 32'h3);
    check("haz_bvalid", 32'(a_bv), 32'h0);
    check("haz_freeze", 32'(a_freeze), 32'h1);
    check("haz_elapsed_hold", 32'(a_el), 32'd10);

    frames(2);
    start_key = 1'b1; step(); start_key = 1'b0;
    check("early_start_state", 32'(a_state), 32'h3);
    check("early_start_lr", 32'(a_lr), 32'h0);
    frames(1);
    restart_a();

    frames(28);
    win_a();
    check("win7_best", 32'(a_best), 32'd7);
    check("win7_bvalid", 32'(a_bv), 32'h1);
    frames(3);
    check("win7_elapsed_hold", 32'(a_el), 32'd7);
    restart_a();
    frames(36);
    win_a();
    check("win9_best", 32'(a_best), 32'd7);
    frames(3);
    restart_a();
    frames(20);
    win_a();
    check("win5_best", 32'(a_best), 32'd5);
    check("win5_bvalid", 32'(a_bv), 32'h1);
    frames(3);
    restart_a();

    frames(6);
    check("mid_elapsed", 32'(a_el), 32'd1);
    Reset = 1'b1; step();
    check_reset_values("midrst");
    Reset = 1'b0; step();

    // Time limit on the 3 s instance.
    start_key = 1'b1; step(); start_key = 1'b0;
    check("b_start_state", 32'(b_state), 32'h1);
    frames(11);
    check("b_t2_elapsed", 32'(b_el), 32'd2);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    check("b_t3_state", 32'(b_state), 32'h1);
    check("b_t3_elapsed", 32'(b_el), 32'd3);
    check("b_t3_bcd", 32'(b_bcd), 32'h003);
    step();
    check("b_timeout_state", 32'(b_state), 32'h3);
    check("b_timeout_freeze", 32'(b_freeze), 32'h1);
    frames(8);
    check("b_timeout_elapsed", 32'(b_el), 32'd3);
    check("b_timeout_bvalid", 32'(b_bv), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/level_flow_controller.md
Name: level_flow_controller

Overview:
Game-flow state machine downstream of the gem/score block. It consumes the gem score count, player door/hazard flags and the per-frame tick, and decides when a level is idle, in play, won or lost. It owns the level timer in binary and BCD and the best-time record, and drives the freeze and level-reset controls back to the player, gem and score logic. Its outputs feed the HUD text renderer and the colour mapper.

Parameters:
GEM_TOTAL, 2, gems required before the doors count as a win (score compared with >=)
FRAMES_PER_SEC, 60, frame_start pulses per elapsed second (>=2)
TIME_LIMIT_S, 255, seconds at which PLAY times out (1..255)
HOLD_FRAMES, 120, frames WIN/LOSE ignores start_key (>=1)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse per frame (VSync edge)
start_key  in  1  one-cycle start/restart pulse
score  in  4  gems collected, from score block
p1_at_door  in  1  player1 overlaps own door
p2_at_door  in  1  player2 overlaps own door
p1_hazard  in  1  player1 touches lethal pool
p2_hazard  in  1  player2 touches lethal pool
state  out  2  00 IDLE, 01 PLAY, 10 WIN, 11 LOSE
freeze  out  1  high when state != PLAY; players ignore input
level_reset  out  1  one-cycle pulse resetting players/gems/score
elapsed_s  out  8  seconds elapsed in current level
elapsed_bcd  out  12  elapsed_s as three BCD digits
best_s  out  8  fastest winning time
best_valid  out  1  best_s holds a recorded win

Behaviour:
- Reset: state=IDLE, freeze=1, level_reset=0, elapsed_s=0, elapsed_bcd=0, frame_cnt=0, hold_cnt=0, best_s=0, best_valid=0. Reset dominates all other inputs.
- All outputs are registered. Every decision uses the pre-edge input values and takes effect on the next edge.
- IDLE: start_key -> PLAY. On that same edge: level_reset=1 for exactly one cycle, elapsed_s/bcd=0, frame_cnt=0.
- PLAY: events are evaluated in this priority order:
  1. p1_hazard | p2_hazard -> LOSE.
  2. elapsed_s == TIME_LIMIT_S -> LOSE.
  3. p1_at_door & p2_at_door & score >= GEM_TOTAL -> WIN.
  start_key is ignored in PLAY.
- Timer: counts only while state == PLAY and no transition fires that cycle.
  - On frame_start: frame_cnt++. When frame_cnt == FRAMES_PER_SEC-1 it wraps to 0 and elapsed_s increments.
  - elapsed_s saturates at TIME_LIMIT_S and never wraps.
  - elapsed_bcd increments in lockstep as digit-wise BCD: ones 9->0 carries into tens; tens 9->0 carries into hundreds.
- Entering WIN: if !best_valid or elapsed_s < best_s, then best_s <= elapsed_s and best_valid <= 1. Equal times do not update.
- Entering WIN or LOSE: hold_cnt = 0. hold_cnt increments on each frame_start, saturating at HOLD_FRAMES.
- WIN/LOSE with hold_cnt == HOLD_FRAMES: start_key -> PLAY with the same level_reset and clearing as from IDLE. best_s and best_valid are kept.
- WIN/LOSE with hold_cnt < HOLD_FRAMES: start_key is ignored.
- elapsed_s holds its final value through WIN/LOSE for HUD display.
- freeze is a registered decode of the next state, so it is valid in the same cycle as state.
- level_reset is never asserted for two consecutive cycles.
- start_key and frame_start in the same cycle in IDLE: the start is taken and the frame is not counted.

Decomposition:
- Shared package game_pkg: state enum typedef (IDLE/PLAY/WIN/LOSE, 2-bit), BCD digit typedef, GEM_TOTAL and FRAMES_PER_SEC defaults shared with the score block.
- One sub-module, bcd_counter3: three-digit BCD incrementer with synchronous clear, enable and saturate-at-value input.
- FSM, frame counter, hold counter and best-time logic stay in the top module.

Test Plan:
- Reset then start_key (FRAMES_PER_SEC=4) -> next cycle state=01, level_reset=1 for 1 cycle, freeze=0, elapsed_s=0.
- PLAY, 40 frame_start pulses -> elapsed_s=10, elapsed_bcd=12'h010; ones digit rolls 9->0 with carry at the 10th second.
- PLAY, score=2, both at_door and p1_hazard in the same cycle -> state=11 (LOSE), best_valid stays 0.
- Win at elapsed_s=7, restart after the hold, win at 9 -> best_s=7; restart, win at 5 -> best_s=5, best_valid=1.
- TIME_LIMIT_S=3 -> LOSE on the cycle after elapsed_s reaches 3; elapsed_s stays 3.
- In LOSE, start_key before HOLD_FRAMES frames -> ignored. After HOLD_FRAMES frames -> PLAY with level_reset pulse. Reset asserted mid-PLAY -> IDLE and all outputs at reset values.
